// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock with a registered carry,
// producing A+B+CIN or A-B-CIN after WIDTH/DIGIT run cycles.
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       state_dbg
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   acc;
    logic               carry;
    logic [CW-1:0]      cnt;

    logic [DIGIT:0]     dsum;
    logic               msb_cin;
    logic [WIDTH-1:0]   acc_shift;

    // Handshake: start is taken only in IDLE (operands and sub/cin sampled with it);
    // busy is high for the N run cycles; done pulses for one cycle with s/cout/ovf valid.
    always_comb begin
        dsum      = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        // On the last digit, bit DIGIT-1 of the digit is bit WIDTH-1 of the word.
        msb_cin   = a_r[DIGIT-1] ^ b_r[DIGIT-1] ^ dsum[DIGIT-1];
        acc_shift = (acc >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_r   <= a_r >> DIGIT;
                    b_r   <= b_r >> DIGIT;
                    carry <= dsum[DIGIT];
                    acc   <= acc_shift;
                    if (cnt == CW'(N - 1)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        s     <= acc_shift;
                        cout  <= dsum[DIGIT];
                        ovf   <= msb_cin ^ dsum[DIGIT];
                        state <= FIN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: three instances (8/1, 16/4, 8/8) checked every cycle against
// an arithmetic reference model, plus hand-computed directed vectors.
module tb_serial_add_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_v[3];
    logic        sub_v[3];
    logic        cin_v[3];
    logic [15:0] a_v[3];
    logic [15:0] b_v[3];

    logic        busy0, busy1, busy2, done0, done1, done2;
    logic        cout0, cout1, cout2, ovf0, ovf1, ovf2;
    logic [1:0]  st0, st1, st2;
    logic [7:0]  s0, s2;
    logic [15:0] s1;

    logic        busy_v[3];
    logic        done_v[3];
    logic        cout_v[3];
    logic        ovf_v[3];
    logic [15:0] s_v[3];

    int wv[3] = '{8, 16, 8};
    int nv[3] = '{8, 4, 1};

    int n_chk  = 0;
    int n_fail = 0;

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]),
        .a(a_v[0][7:0]), .b(b_v[0][7:0]), .cin(cin_v[0]),
        .busy(busy0), .done(done0), .s(s0), .cout(cout0), .ovf(ovf0), .state_dbg(st0)
    );

    serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
        .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]),
        .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1), .state_dbg(st1)
    );

    serial_add_sub #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
        .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_v[2]),
        .a(a_v[2][7:0]), .b(b_v[2][7:0]), .cin(cin_v[2]),
        .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2), .state_dbg(st2)
    );

    always_comb begin
        busy_v[0] = busy0;  busy_v[1] = busy1;  busy_v[2] = busy2;
        done_v[0] = done0;  done_v[1] = done1;  done_v[2] = done2;
        cout_v[0] = cout0;  cout_v[1] = cout1;  cout_v[2] = cout2;
        ovf_v[0]  = ovf0;   ovf_v[1]  = ovf1;   ovf_v[2]  = ovf2;
        s_v[0]    = {8'h00, s0};
        s_v[1]    = s1;
        s_v[2]    = {8'h00, s2};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference result {cout, ovf, s[15:0]} from plain integer arithmetic.
    function automatic logic [17:0] ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                           input logic sb, input logic ci);
        int unsigned mask, hmask, aa, bb, c, full, low, co, cm;
        mask  = (32'd1 << w) - 1;
        hmask = mask >> 1;
        aa    = a & mask;
        bb    = sb ? (~{16'h0000, b}) & mask : b & mask;
        c     = {31'd0, ci ^ sb};
        full  = aa + bb + c;
        low   = (aa & hmask) + (bb & hmask) + c;
        co    = (full >> w) & 1;
        cm    = (low >> (w - 1)) & 1;
        return {co[0], co[0] ^ cm[0], full[15:0] & mask[15:0]};
    endfunction

    // Timing model: t = cycle index since the accepting edge (-1 when idle).
    int          t[3] = '{-1, -1, -1};
    logic [17:0] pend[3];
    logic [17:0] held[3];
    bit          armed = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            armed <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                t[i]    <= -1;
                held[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (t[i] == -1) begin
                    if (start_v[i] === 1'b1) begin
                        pend[i] <= ref_op(wv[i], a_v[i], b_v[i], sub_v[i], cin_v[i]);
                        t[i]    <= 1;
                    end
                end else if (t[i] == nv[i] + 1) begin
                    t[i] <= -1;
                end else begin
                    t[i] <= t[i] + 1;
                    if (t[i] + 1 == nv[i] + 1) held[i] <= pend[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("busy[%0d] t=%0d", i, t[i]), {31'd0, busy_v[i]},
                    {31'd0, (t[i] >= 1 && t[i] <= nv[i])});
                chk($sformatf("done[%0d] t=%0d", i, t[i]), {31'd0, done_v[i]},
                    {31'd0, (t[i] == nv[i] + 1)});
                chk($sformatf("s[%0d]", i), {16'd0, s_v[i]}, {16'd0, held[i][15:0]});
                chk($sformatf("cout[%0d]", i), {31'd0, cout_v[i]}, {31'd0, held[i][17]});
                chk($sformatf("ovf[%0d]", i), {31'd0, ovf_v[i]}, {31'd0, held[i][16]});
            end
        end
    end

    task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic sb, input logic ci, output int nbusy, output int dk);
        @(posedge clk); #1;
        a_v[i] = a; b_v[i] = b; sub_v[i] = sb; cin_v[i] = ci; start_v[i] = 1'b1;
        @(posedge clk); #1;
        start_v[i] = 1'b0;
        a_v[i]     = 16'($urandom);
        b_v[i]     = 16'($urandom);
        sub_v[i]   = 1'($urandom_range(0, 1));
        cin_v[i]   = 1'($urandom_range(0, 1));
        nbusy = 0;
        dk    = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (busy_v[i]) nbusy++;
            if (done_v[i]) begin
                dk = k;
                break;
            end
        end
        if (dk == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout[%0d]: no done within 60 cycles, expected one at cycle %0d", i, nv[i] + 1);
        end
    endtask

    initial begin
        int nb, dk, ndone;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0; sub_v[i] = 1'b0; cin_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset busy", {31'd0, busy0}, 0);
        chk("reset done", {31'd0, done0}, 0);
        chk("reset s", {24'd0, s0}, 0);

        // Directed vectors with hand-computed results (instance W=8, D=1).
        run_op(0, 16'h5A, 16'h3C, 1'b0, 1'b0, nb, dk);
        chk("t1 s", {24'd0, s0}, 32'h96);
        chk("t1 cout", {31'd0, cout0}, 0);
        chk("t1 ovf", {31'd0, ovf0}, 1);
        chk("t1 busy cycles", nb, 8);
        chk("t1 done cycle", dk, 9);

        run_op(0, 16'hFF, 16'h01, 1'b0, 1'b0, nb, dk);
        chk("t2a s", {24'd0, s0}, 32'h00);
        chk("t2a cout", {31'd0, cout0}, 1);
        chk("t2a ovf", {31'd0, ovf0}, 0);

        run_op(0, 16'h7F, 16'h00, 1'b0, 1'b1, nb, dk);
        chk("t2b s", {24'd0, s0}, 32'h80);
        chk("t2b ovf", {31'd0, ovf0}, 1);

        run_op(0, 16'h10, 16'h20, 1'b1, 1'b0, nb, dk);
        chk("t3a s", {24'd0, s0}, 32'hF0);
        chk("t3a cout", {31'd0, cout0}, 0);
        chk("t3a ovf", {31'd0, ovf0}, 0);

        run_op(0, 16'h80, 16'h01, 1'b1, 1'b0, nb, dk);
        chk("t3b s", {24'd0, s0}, 32'h7F);
        chk("t3b cout", {31'd0, cout0}, 1);
        chk("t3b ovf", {31'd0, ovf0}, 1);

        // START pulsed again in run cycle 3 with other operands must be ignored.
        @(posedge clk); #1;
        a_v[0] = 16'h5A; b_v[0] = 16'h3C; sub_v[0] = 1'b0; cin_v[0] = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_v[0] = 16'hFF; b_v[0] = 16'hFF; sub_v[0] = 1'b1; start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        chk("t4 done pulses", ndone, 1);
        chk("t4 s", {24'd0, s0}, 32'h96);

        // Reset in run cycle 4 discards the operation and clears the outputs.
        @(posedge clk); #1;
        a_v[0] = 16'h10; b_v[0] = 16'h20; sub_v[0] = 1'b1; cin_v[0] = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5 busy", {31'd0, busy0}, 0);
        chk("t5 s", {24'd0, s0}, 0);
        chk("t5 ovf", {31'd0, ovf0}, 0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        chk("t5 no done", ndone, 0);
        run_op(0, 16'h7F, 16'h00, 1'b0, 1'b1, nb, dk);
        chk("t5 restart s", {24'd0, s0}, 32'h80);

        // Random operands on the wider/faster configurations.
        for (int i = 1; i < 3; i++) begin
            for (int r = 0; r < 1000; r++) begin
                run_op(i, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), nb, dk);
                chk($sformatf("latency[%0d]", i), dk, nv[i] + 1);
            end
        end
        for (int r = 0; r < 50; r++) begin
            run_op(0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), nb, dk);
            chk("latency[0]", dk, nv[0] + 1);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
